// File: rtl/rs_issue_select.sv
// ============================================================================
// rs_issue_select : reservation-station wakeup, oldest-ready select and issue
// Rev 1.0
// ============================================================================
`default_nettype none

module rs_issue_select #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 7,
  parameter int PAYLOAD_W = 32,
  parameter int AGE_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  input  logic [$clog2(DEPTH)-1:0] disp_index,
  input  logic [TAG_W-1:0]         disp_ps1,
  input  logic                     disp_ps1_rdy,
  input  logic [TAG_W-1:0]         disp_ps2,
  input  logic                     disp_ps2_rdy,
  input  logic [TAG_W-1:0]         disp_pd,
  input  logic [PAYLOAD_W-1:0]     disp_payload,
  input  logic                     cdb0_valid,
  input  logic [TAG_W-1:0]         cdb0_tag,
  input  logic                     cdb1_valid,
  input  logic [TAG_W-1:0]         cdb1_tag,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [TAG_W-1:0]         iss_ps1,
  output logic [TAG_W-1:0]         iss_ps2,
  output logic [TAG_W-1:0]         iss_pd,
  output logic [PAYLOAD_W-1:0]     iss_payload,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int                 c_IDX_W   = $clog2(DEPTH);
  localparam logic [AGE_W-1:0]   c_AGE_MAX = '1;

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_rdy1;
  logic [DEPTH-1:0]     r_rdy2;
  logic [AGE_W-1:0]     r_age     [DEPTH];
  logic [TAG_W-1:0]     r_ps1     [DEPTH];
  logic [TAG_W-1:0]     r_ps2     [DEPTH];
  logic [TAG_W-1:0]     r_pd      [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];

  logic                 r_iss_valid;
  logic [TAG_W-1:0]     r_iss_ps1;
  logic [TAG_W-1:0]     r_iss_ps2;
  logic [TAG_W-1:0]     r_iss_pd;
  logic [PAYLOAD_W-1:0] r_iss_payload;

  logic [DEPTH-1:0]     w_hit1;
  logic [DEPTH-1:0]     w_hit2;
  logic                 w_dhit1;
  logic                 w_dhit2;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_win;
  logic [AGE_W-1:0]     w_best_age;
  logic                 w_load_en;
  logic                 w_issue;
  logic [c_IDX_W:0]     w_occ;

  // CDB tag matches for resident entries and for the entry being dispatched
  always_comb begin
    w_hit1  = '0;
    w_hit2  = '0;
    w_dhit1 = (cdb0_valid && (cdb0_tag == disp_ps1)) || (cdb1_valid && (cdb1_tag == disp_ps1));
    w_dhit2 = (cdb0_valid && (cdb0_tag == disp_ps2)) || (cdb1_valid && (cdb1_tag == disp_ps2));
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = (cdb0_valid && (cdb0_tag == r_ps1[i])) || (cdb1_valid && (cdb1_tag == r_ps1[i]));
      w_hit2[i] = (cdb0_valid && (cdb0_tag == r_ps2[i])) || (cdb1_valid && (cdb1_tag == r_ps2[i]));
    end
  end

  // Strict greater-than keeps the lowest index on equal ages
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_rdy1[i] && r_rdy2[i] && (!w_found || (r_age[i] > w_best_age))) begin
        w_found    = 1'b1;
        w_win      = c_IDX_W'(i);
        w_best_age = r_age[i];
      end
    end
  end

  assign w_load_en = !r_iss_valid || iss_ready;
  assign w_issue   = w_load_en && w_found;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          if (w_hit1[i]) r_rdy1[i] <= 1'b1;
          if (w_hit2[i]) r_rdy2[i] <= 1'b1;
          if (r_age[i] != c_AGE_MAX) r_age[i] <= r_age[i] + 1'b1;
          if (w_issue && (w_win == c_IDX_W'(i))) r_valid[i] <= 1'b0;
        end else if (disp_valid && (disp_index == c_IDX_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_rdy1[i]  <= disp_ps1_rdy || w_dhit1;
          r_rdy2[i]  <= disp_ps2_rdy || w_dhit2;
          r_age[i]   <= '0;
        end
      end
    end
  end

  // Operand fields only matter while the valid bit is set, so they need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_valid && (disp_index == c_IDX_W'(i)) && !r_valid[i]) begin
        r_ps1[i]     <= disp_ps1;
        r_ps2[i]     <= disp_ps2;
        r_pd[i]      <= disp_pd;
        r_payload[i] <= disp_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_iss_valid   <= 1'b0;
      r_iss_ps1     <= '0;
      r_iss_ps2     <= '0;
      r_iss_pd      <= '0;
      r_iss_payload <= '0;
    end else if (w_load_en) begin
      r_iss_valid <= w_found;
      if (w_found) begin
        r_iss_ps1     <= r_ps1[w_win];
        r_iss_ps2     <= r_ps2[w_win];
        r_iss_pd      <= r_pd[w_win];
        r_iss_payload <= r_payload[w_win];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + {{c_IDX_W{1'b0}}, r_valid[i]};
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_ps1     = r_iss_ps1;
  assign iss_ps2     = r_iss_ps2;
  assign iss_pd      = r_iss_pd;
  assign iss_payload = r_iss_payload;
  assign entry_valid = r_valid;
  assign occupancy   = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_select.sv
// ============================================================================
// tb_rs_issue_select : directed vector bench for rs_issue_select
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rs_issue_select;

  localparam int DEPTH     = 8;
  localparam int TAG_W     = 7;
  localparam int PAYLOAD_W = 32;
  localparam int AGE_W     = 4;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 disp_valid;
  logic [2:0]           disp_index;
  logic [TAG_W-1:0]     disp_ps1;
  logic                 disp_ps1_rdy;
  logic [TAG_W-1:0]     disp_ps2;
  logic                 disp_ps2_rdy;
  logic [TAG_W-1:0]     disp_pd;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 cdb0_valid;
  logic [TAG_W-1:0]     cdb0_tag;
  logic                 cdb1_valid;
  logic [TAG_W-1:0]     cdb1_tag;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [TAG_W-1:0]     iss_ps1;
  logic [TAG_W-1:0]     iss_ps2;
  logic [TAG_W-1:0]     iss_pd;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [DEPTH-1:0]     entry_valid;
  logic [3:0]           occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  rs_issue_select #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .AGE_W(AGE_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .disp_valid(disp_valid), .disp_index(disp_index),
    .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_pd(disp_pd), .disp_payload(disp_payload),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd), .iss_payload(iss_payload),
    .entry_valid(entry_valid), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [2:0]  di;
    logic [6:0]  ps1;
    logic        r1;
    logic [6:0]  ps2;
    logic        r2;
    logic [6:0]  pd;
    logic [31:0] pl;
    logic        c0v;
    logic [6:0]  c0t;
    logic        c1v;
    logic [6:0]  c1t;
    logic        x_iv;
    logic [6:0]  x_pd;
    logic [31:0] x_pl;
    logic [7:0]  x_ev;
    logic [3:0]  x_occ;
  } vec_t;

  function automatic vec_t mk(
    input logic dv, input logic [2:0] di, input logic [6:0] ps1, input logic r1,
    input logic [6:0] ps2, input logic r2, input logic [6:0] pd, input logic [31:0] pl,
    input logic c0v, input logic [6:0] c0t, input logic c1v, input logic [6:0] c1t,
    input logic x_iv, input logic [6:0] x_pd, input logic [31:0] x_pl,
    input logic [7:0] x_ev, input logic [3:0] x_occ);
    vec_t v;
    v.dv = dv; v.di = di; v.ps1 = ps1; v.r1 = r1; v.ps2 = ps2; v.r2 = r2;
    v.pd = pd; v.pl = pl; v.c0v = c0v; v.c0t = c0t; v.c1v = c1v; v.c1t = c1t;
    v.x_iv = x_iv; v.x_pd = x_pd; v.x_pl = x_pl; v.x_ev = x_ev; v.x_occ = x_occ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_index = '0; disp_ps1 = '0; disp_ps1_rdy = 1'b0;
    disp_ps2 = '0; disp_ps2_rdy = 1'b0; disp_pd = '0; disp_payload = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb1_valid = 1'b0; cdb1_tag = '0;
    flush = 1'b0;
  endtask

  task automatic disp(input int idx, input int p1, input logic r1, input int p2,
                      input logic r2, input int pd, input int pl);
    disp_valid = 1'b1; disp_index = 3'(idx);
    disp_ps1 = 7'(p1); disp_ps1_rdy = r1;
    disp_ps2 = 7'(p2); disp_ps2_rdy = r2;
    disp_pd = 7'(pd); disp_payload = 32'(pl);
  endtask

  vec_t vecs [18];

  initial begin
    reset_n   = 1'b0;
    iss_ready = 1'b1;
    idle();

    // {dispatch..., cdb0, cdb1, expected iss_valid/pd/payload, entry_valid, occupancy}
    vecs[0]  = mk(1,3, 5,1, 6,1, 9,'hA5, 0,0, 0,0,  0,0,0,     'h08,1);
    vecs[1]  = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  1,9,'hA5,  'h00,0);
    vecs[2]  = mk(1,0,12,0,13,1,14,'h0C, 0,0, 0,0,  0,0,0,     'h01,1);
    vecs[3]  = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  0,0,0,     'h01,1);
    vecs[4]  = mk(0,0, 0,0, 0,0, 0,0,    0,0, 1,12, 0,0,0,     'h01,1);
    vecs[5]  = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  1,14,'h0C, 'h00,0);
    vecs[6]  = mk(1,7,30,0,31,0, 2,'h77, 1,30,1,31, 0,0,0,     'h80,1);
    vecs[7]  = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  1,2,'h77,  'h00,0);
    vecs[8]  = mk(1,2, 0,0, 0,0, 3,'h33, 0,0, 0,0,  0,0,0,     'h04,1);
    vecs[9]  = mk(0,0, 0,0, 0,0, 0,0,    1,0, 0,0,  0,0,0,     'h04,1);
    vecs[10] = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  1,3,'h33,  'h00,0);
    vecs[11] = mk(1,1, 1,1, 1,1, 4,'h44, 0,0, 0,0,  0,0,0,     'h02,1);
    vecs[12] = mk(1,6, 1,1, 1,1, 5,'h55, 0,0, 0,0,  1,4,'h44,  'h40,1);
    vecs[13] = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  1,5,'h55,  'h00,0);
    vecs[14] = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  0,0,0,     'h00,0);
    vecs[15] = mk(1,1, 1,1, 1,1, 8,'h81, 0,0, 0,0,  0,0,0,     'h02,1);
    vecs[16] = mk(1,1, 1,1, 1,1, 9,'h91, 0,0, 0,0,  1,8,'h81,  'h00,0);
    vecs[17] = mk(0,0, 0,0, 0,0, 0,0,    0,0, 0,0,  0,0,0,     'h00,0);

    step(); step();
    chk("reset iss_valid", 32'(iss_valid), 0);
    chk("reset entry_valid", 32'(entry_valid), 0);
    chk("reset occupancy", 32'(occupancy), 0);
    chk("reset iss_pd", 32'(iss_pd), 0);
    chk("reset iss_payload", iss_payload, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      disp_valid = vecs[k].dv; disp_index = vecs[k].di;
      disp_ps1 = vecs[k].ps1; disp_ps1_rdy = vecs[k].r1;
      disp_ps2 = vecs[k].ps2; disp_ps2_rdy = vecs[k].r2;
      disp_pd = vecs[k].pd; disp_payload = vecs[k].pl;
      cdb0_valid = vecs[k].c0v; cdb0_tag = vecs[k].c0t;
      cdb1_valid = vecs[k].c1v; cdb1_tag = vecs[k].c1t;
      step();
      chk($sformatf("vec%0d iss_valid", k), 32'(iss_valid), 32'(vecs[k].x_iv));
      chk($sformatf("vec%0d entry_valid", k), 32'(entry_valid), 32'(vecs[k].x_ev));
      chk($sformatf("vec%0d occupancy", k), 32'(occupancy), 32'(vecs[k].x_occ));
      if (vecs[k].x_iv) begin
        chk($sformatf("vec%0d iss_pd", k), 32'(iss_pd), 32'(vecs[k].x_pd));
        chk($sformatf("vec%0d iss_payload", k), iss_payload, vecs[k].x_pl);
      end
    end
    idle();

    // Oldest first: slot 5 is three cycles older than slot 1
    disp(5, 20, 0, 21, 1, 50, 'h500); step();
    idle(); step(); step();
    disp(1, 20, 0, 21, 1, 51, 'h501); step();
    idle(); cdb0_valid = 1'b1; cdb0_tag = 7'd20; step();
    chk("age wake not early", 32'(iss_valid), 0);
    idle(); step();
    chk("age first valid", 32'(iss_valid), 1);
    chk("age first pd", 32'(iss_pd), 50);
    step();
    chk("age second pd", 32'(iss_pd), 51);
    chk("age second ps1", 32'(iss_ps1), 20);
    step();
    chk("age drained", 32'(iss_valid), 0);

    // Saturated equal ages: lowest index wins
    disp(6, 22, 0, 23, 1, 60, 'h600); step();
    disp(2, 22, 0, 23, 1, 61, 'h601); step();
    idle();
    repeat (18) step();
    cdb1_valid = 1'b1; cdb1_tag = 7'd22; step();
    idle(); step();
    chk("tie first pd", 32'(iss_pd), 61);
    step();
    chk("tie second pd", 32'(iss_pd), 60);
    chk("tie second ps2", 32'(iss_ps2), 23);
    step();
    chk("tie drained ev", 32'(entry_valid), 0);

    // Full station; extra dispatch to an occupied slot is dropped
    for (int i = 0; i < 8; i++) begin
      disp(i, 100, 0, 101, 1, i, i); step();
    end
    chk("full occupancy", 32'(occupancy), 8);
    chk("full entry_valid", 32'(entry_valid), 'hFF);
    disp(4, 1, 1, 1, 1, 99, 'h999); step();
    chk("full extra occupancy", 32'(occupancy), 8);
    chk("full extra no issue", 32'(iss_valid), 0);
    idle(); cdb0_valid = 1'b1; cdb0_tag = 7'd100; step();
    idle();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("full drain%0d valid", i), 32'(iss_valid), 1);
      chk($sformatf("full drain%0d pd", i), 32'(iss_pd), 32'(i));
      chk($sformatf("full drain%0d payload", i), iss_payload, 32'(i));
    end
    step();
    chk("full drained valid", 32'(iss_valid), 0);
    chk("full drained occupancy", 32'(occupancy), 0);

    // Back-pressure
    iss_ready = 1'b0;
    disp(4, 1, 1, 1, 1, 70, 'h700); step();
    chk("stall load ev", 32'(entry_valid), 'h10);
    disp(3, 1, 1, 1, 1, 71, 'h701); step();
    chk("stall first valid", 32'(iss_valid), 1);
    chk("stall first pd", 32'(iss_pd), 70);
    disp(0, 1, 1, 1, 1, 72, 'h702); step();
    chk("stall ev", 32'(entry_valid), 'h09);
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall%0d valid", k), 32'(iss_valid), 1);
      chk($sformatf("stall%0d pd", k), 32'(iss_pd), 70);
      chk($sformatf("stall%0d payload", k), iss_payload, 'h700);
      chk($sformatf("stall%0d occupancy", k), 32'(occupancy), 2);
    end
    iss_ready = 1'b1; step();
    chk("release pd", 32'(iss_pd), 71);
    chk("release ev", 32'(entry_valid), 'h01);
    iss_ready = 1'b0; step();
    chk("restall pd", 32'(iss_pd), 71);
    chk("restall valid", 32'(iss_valid), 1);

    // Flush with dispatch in the same cycle, op held in the issue register
    flush = 1'b1; disp(5, 1, 1, 1, 1, 73, 'h703); step();
    chk("flush valid", 32'(iss_valid), 0);
    chk("flush ev", 32'(entry_valid), 0);
    chk("flush occupancy", 32'(occupancy), 0);
    chk("flush pd", 32'(iss_pd), 0);
    chk("flush payload", iss_payload, 0);
    idle(); step();
    chk("post flush ev", 32'(entry_valid), 0);
    chk("post flush valid", 32'(iss_valid), 0);

    // Reset mid-stall
    disp(2, 1, 1, 1, 1, 80, 'h800); step();
    idle(); step();
    chk("rst stall pd", 32'(iss_pd), 80);
    disp(6, 1, 1, 1, 1, 81, 'h801); step();
    chk("rst stall ev", 32'(entry_valid), 'h40);
    idle(); reset_n = 1'b0; step();
    chk("rst mid valid", 32'(iss_valid), 0);
    chk("rst mid ev", 32'(entry_valid), 0);
    chk("rst mid occupancy", 32'(occupancy), 0);
    chk("rst mid pd", 32'(iss_pd), 0);
    reset_n = 1'b1; iss_ready = 1'b1; step();
    chk("post rst valid", 32'(iss_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Read/issue side of the reservation station. Holds DEPTH entries written by dispatch at slot indices chosen by the allocation-side free-slot logic.
- Tracks source-operand readiness from two CDB wakeup ports.
- Selects the oldest ready entry each cycle, frees its slot, and presents it to the functional unit through a registered valid/ready issue port.
- Exports the occupancy vector back to the allocation side.

Parameters:
DEPTH, 8, number of RS entries (power of two)
TAG_W, 7, physical register tag width
PAYLOAD_W, 32, opaque op/immediate/ROB payload carried per entry
AGE_W, 4, per-entry age counter width (saturating)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
flush  in  1  clear all entries and the issue register
disp_valid  in  1  write one entry this cycle
disp_index  in  $clog2(DEPTH)  target slot
disp_ps1  in  TAG_W  source 1 tag
disp_ps1_rdy  in  1  source 1 already ready
disp_ps2  in  TAG_W  source 2 tag
disp_ps2_rdy  in  1  source 2 already ready
disp_pd  in  TAG_W  destination tag
disp_payload  in  PAYLOAD_W  opaque payload
cdb0_valid  in  1  wakeup broadcast 0
cdb0_tag  in  TAG_W  tag 0
cdb1_valid  in  1  wakeup broadcast 1
cdb1_tag  in  TAG_W  tag 1
iss_valid  out  1  issue register holds an op
iss_ready  in  1  FU accepts
iss_ps1  out  TAG_W  issued source 1 tag
iss_ps2  out  TAG_W  issued source 2 tag
iss_pd  out  TAG_W  issued destination tag
iss_payload  out  PAYLOAD_W  issued payload
entry_valid  out  DEPTH  per-slot occupancy, to the free-slot finder
occupancy  out  $clog2(DEPTH)+1  count of valid entries

Behaviour:
- Reset (reset_n=0 at edge):
  - All entry valid, ready and age bits cleared.
  - iss_valid=0; iss_* data=0; entry_valid=0; occupancy=0.
  - Reset asserted mid-stall drops the held op.
- Flush has the same effect as reset and takes priority over dispatch, wakeup and issue in the same cycle.
- Dispatch:
  - When disp_valid=1, the slot is written at the edge with age=0.
  - Ready bit = disp_psX_rdy OR (a cdbN_valid with cdbN_tag==disp_psX in the same cycle).
  - Dispatch to an already-valid slot is ignored; the entry is unchanged.
  - A slot freed by issue in cycle N may be re-dispatched in cycle N+1, not in cycle N.
- Wakeup:
  - Every valid entry whose psX equals a valid CDB tag sets psX_rdy at the edge.
  - Both CDB ports are evaluated in the same cycle.
  - Tag 0 is not special.
- Age: each valid entry's age increments by 1 per cycle, saturating at 2^AGE_W-1.
- Select (combinational on registered state):
  - Candidates are valid entries with ps1_rdy AND ps2_rdy.
  - Pick the maximum age; ties go to the lowest index.
- Issue register:
  - Loads when `load_en = !iss_valid || iss_ready`.
  - On load with a candidate: iss_* take the winner's fields, iss_valid=1, and the winner's valid bit clears at the same edge.
  - On load with no candidate: iss_valid=0.
  - While iss_valid=1 and iss_ready=0, all iss_* hold stable and no entry is removed.
- Latency:
  - An entry ready at cycle N appears on iss_* at N+1 if load_en.
  - A CDB wakeup at N gives iss_valid at N+2 at the earliest.
- Throughput: one issue per cycle under continuous iss_ready=1.
- entry_valid and occupancy reflect registered state; dispatch and issue in the same cycle leave occupancy unchanged.
- Full: occupancy=DEPTH; further dispatches are ignored per the occupied-slot rule.

Test Plan:
- Reset, then dispatch slot 3 (ps1=5 rdy, ps2=6 rdy, pd=9, payload=0xA5) with iss_ready=1 -> iss_valid=1 next cycle, iss_pd=9, iss_payload=0xA5; entry_valid[3]=0 that same cycle; occupancy back to 0.
- Dispatch slot 0 with ps1=12 not ready; cdb1 tag=12 two cycles later -> iss_valid rises exactly 2 cycles after the broadcast, not earlier.
- Ready entries in slots 5 (older by 3 cycles) and 1 -> slot 5 issues first, slot 1 the following cycle; equal ages in slots 2 and 6 -> slot 2 issues first.
- Hold iss_ready=0 for 4 cycles with iss_valid=1 -> iss_* stable, occupancy unchanged; release -> next oldest ready entry loads the cycle after acceptance.
- Fill all 8 slots with not-ready sources -> occupancy=8, entry_valid=0xFF; extra dispatch to slot 4 leaves it unchanged.
- Dispatch and flush in the same cycle, with a stalled op present -> all entries cleared, iss_valid=0, occupancy=0 next cycle; same result for reset_n=0 mid-stall.
